dac_spi_rx: RTL and testbench

//  Receiving end of the DAC SPI link: decodes 24-bit frames {comm[3:0], addr[3:0], data[15:0]}, MSB first.

---
 rtl/dac_spi_pkg.sv | 20 ++
 rtl/spi_in_sync.sv | 37 +++
 rtl/dac_spi_rx.sv | 148 ++++++++++++++
 tb/tb_dac_spi_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared constants and state type for the DAC SPI receiver
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam int COMM_W     = 4;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 5;

  localparam logic [COMM_W-1:0] CMD_WRITE = 4'h3;
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } rx_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - metastability chain plus registered level/rise/fall for one SPI pin
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // level, rise and fall all change on the same edge so they stay mutually consistent
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      level_q <= chain_q[STAGES-1];
      rise_q  <= chain_q[STAGES-1] & ~level_q;
      fall_q  <= ~chain_q[STAGES-1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/dac_spi_rx.sv
// rtl/dac_spi_rx.sv - DAC SPI target emulation: decodes 24-bit frames into a valid/error strobe
// Optional readback register bank enabled by macro DAC_SPI_RX_REGFILE_EN.
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_sync,
  input  logic              spi_data,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [COMM_W-1:0] rx_comm,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [DATA_W-1:0] rx_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sync_lvl, sync_rise, sync_fall;
  logic data_lvl, data_rise, data_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(clk), .rst(rst), .din(spi_sync),
    .level(sync_lvl), .rise(sync_rise), .fall(sync_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_data_sync (
    .clk(clk), .rst(rst), .din(spi_data),
    .level(data_lvl), .rise(data_rise), .fall(data_fall)
  );

  logic unused_edges;
  assign unused_edges = sclk_lvl ^ sclk_rise ^ data_rise ^ data_fall;

  rx_state_t               state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [COMM_W-1:0]       rx_comm_q, rx_comm_d;
  logic [ADDR_W-1:0]       rx_addr_q, rx_addr_d;
  logic [DATA_W-1:0]       rx_data_q, rx_data_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      rx_comm_q     <= '0;
      rx_addr_q     <= '0;
      rx_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_comm_q     <= rx_comm_d;
      rx_addr_q     <= rx_addr_d;
      rx_data_q     <= rx_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    rx_comm_d     = rx_comm_q;
    rx_addr_d     = rx_addr_q;
    rx_data_d     = rx_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    case (state_q)
      // a frame already running when we leave reset must not be accepted
      WAIT_IDLE: begin
        if (sync_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (sync_fall) begin
          shreg_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // sync_rise takes priority: a coincident sclk edge is not shifted in
        if (sync_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == FRAME_CNT) begin
            rx_comm_d     = shreg_q[FRAME_BITS-1 -: COMM_W];
            rx_addr_d     = shreg_q[DATA_W +: ADDR_W];
            rx_data_d     = shreg_q[DATA_W-1:0];
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_fall) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], data_lvl};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign rx_comm     = rx_comm_q;
  assign rx_addr     = rx_addr_q;
  assign rx_data     = rx_data_q;

`ifdef DAC_SPI_RX_REGFILE_EN
  logic [DATA_W-1:0] bank_q [16];
  logic [DATA_W-1:0] rd_data_q;
  logic              bank_we;

  assign bank_we = frame_valid_q && (rx_comm_q == CMD_WRITE);

  // write-through so a fresh write is readable one cycle after frame_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (bank_we) bank_q[rx_addr_q] <= rx_data_q;
      rd_data_q <= (bank_we && (rd_addr == rx_addr_q)) ? rx_data_q : bank_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb/tb_dac_spi_rx.sv - scoreboard bench for dac_spi_rx with directed SPI frames
module tb_dac_spi_rx;

  logic        clk;
  logic        rst;
  logic        spi_sclk;
  logic        spi_sync;
  logic        spi_data;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  rx_comm;
  logic [3:0]  rx_addr;
  logic [15:0] rx_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  dac_spi_rx dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_sync(spi_sync), .spi_data(spi_data),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .rx_comm(rx_comm), .rx_addr(rx_addr), .rx_data(rx_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [3:0]  comm;
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  int passed = 0;
  int total  = 0;

  logic [3:0]  m_comm = 4'h0;
  logic [3:0]  m_addr = 4'h0;
  logic [15:0] m_data = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits go out MSB first; data changes while sclk is high and is sampled on its fall
  task automatic send_frame(input logic [31:0] word, input int nbits, input int half,
                            input int gap, input int rst_at);
    exp_t e;
    spi_sync = 1'b0;
    tick(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      if ((nbits - 1 - i) == rst_at) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_comm = 4'h0;
        m_addr = 4'h0;
        m_data = 16'h0;
      end
      spi_data = word[i];
      tick(half);
      spi_sclk = 1'b0;
      tick(half);
      spi_sclk = 1'b1;
    end
    tick(half);
    spi_sync = 1'b1;
    if (rst_at < 0) begin
      if (nbits == 24) begin
        m_comm = word[23:20];
        m_addr = word[19:16];
        m_data = word[15:0];
        e.is_err = 1'b0;
      end else begin
        e.is_err = 1'b1;
      end
      e.comm = m_comm;
      e.addr = m_addr;
      e.data = m_data;
      e.cyc  = cyc + 4;
      sb_q.push_back(e);
    end
    tick(gap);
  endtask

  logic fv_prev = 1'b0;
  logic fe_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      exp_t e;
      check("exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
      check("pulse_width", {31'd0, (fv_prev & frame_valid) | (fe_prev & frame_err)}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_err, frame_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("rx_comm", {28'd0, rx_comm}, {28'd0, e.comm});
        check("rx_addr", {28'd0, rx_addr}, {28'd0, e.addr});
        check("rx_data", {16'd0, rx_data}, {16'd0, e.data});
        check("latency", cyc, e.cyc);
      end
    end
    fv_prev <= frame_valid;
    fe_prev <= frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    spi_sclk = 1'b1;
    spi_sync = 1'b1;
    spi_data = 1'b0;
    rd_addr  = 4'h0;
    tick(3);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_comm", {28'd0, rx_comm}, 32'd0);
    check("rst_rx_addr", {28'd0, rx_addr}, 32'd0);
    check("rst_rx_data", {16'd0, rx_data}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    tick(8);

    send_frame(32'h35ABCD, 24, 16, 10, -1);
    send_frame(32'hFFFFF, 20, 8, 10, -1);
    send_frame(32'h2AAAAAA, 26, 8, 10, -1);
    send_frame(32'h310001, 24, 8, 10, -1);

    send_frame(32'h3CCCCC, 24, 6, 10, 10);
    check("midrst_rx_comm", {28'd0, rx_comm}, 32'd0);
    check("midrst_rx_data", {16'd0, rx_data}, 32'd0);
    send_frame(32'h39C3A5, 24, 6, 10, -1);

    send_frame(32'h321234, 24, 4, 3, -1);
    send_frame(32'h325678, 24, 4, 10, -1);

    rd_addr = 4'h7;
`ifdef DAC_SPI_RX_REGFILE_EN
    send_frame(32'h37BEEF, 24, 6, 10, -1);
    tick(2);
    check("bank7_write", {16'd0, rd_data}, 32'h0000BEEF);
    send_frame(32'h170000, 24, 6, 10, -1);
    tick(2);
    check("bank7_kept", {16'd0, rd_data}, 32'h0000BEEF);
    rd_addr = 4'h2;
    tick(2);
    check("bank2_write", {16'd0, rd_data}, 32'h00005678);
`else
    send_frame(32'h37BEEF, 24, 6, 10, -1);
    tick(2);
    check("rd_data_tied", {16'd0, rd_data}, 32'd0);
`endif

    tick(20);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
